// File: rtl/gemm_pkg.sv
// Shared types and constants for the GEMM datapath.
// Holds the dst output-stage batch length and FSM state encoding.
package gemm_pkg;

   localparam int unsigned DST_BEATS = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } dst_state_t;

endpackage

// File: rtl/axis_skid.sv
// Two-entry skid buffer: a main register driving the output plus one overflow register.
// in_ready is registered and reflects only whether the overflow register is empty.
module axis_skid #(
   parameter int unsigned W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid_q, main_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] main_data_q, main_data_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         in_ready_q;
   logic         accept;
   logic         out_fire;

   assign accept   = in_valid & in_ready_q;
   assign out_fire = main_valid_q & out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (skid_valid_q) begin
         // in_ready is low here, so only the drain path can move anything
         if (out_fire) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_valid_q || out_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end
      end else if (out_fire) begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= ~skid_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;

endmodule

// File: rtl/dst_axis_out.sv
// dst-side output stage: counts beats/batches of result words, tags the final word with tlast,
// and streams them through a skid buffer onto an AXI4-Stream master; pulses done when drained.
module dst_axis_out
   import gemm_pkg::*;
#(
   parameter int unsigned DW      = 32,
   parameter int unsigned BEATS   = DST_BEATS,
   parameter int unsigned BATCH_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic [BATCH_W-1:0] nbatch,
   input  logic               dst_valid,
   input  logic [DW-1:0]      dst_data,
   output logic               dst_ready,
   output logic               m_axis_tvalid,
   output logic [DW-1:0]      m_axis_tdata,
   output logic               m_axis_tlast,
   input  logic               m_axis_tready,
   output logic               busy,
   output logic               done
);

   localparam int unsigned    BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS - 1);

   dst_state_t         state_q, state_d;
   logic [BCW-1:0]     beat_q, beat_d;
   logic [BATCH_W-1:0] batch_q, batch_d;
   logic [BATCH_W-1:0] nbatch_q, nbatch_d;
   logic               started_q, started_d;
   logic               done_q, done_d;

   logic               flush;
   logic               skid_in_ready;
   logic               skid_out_valid;
   logic [DW:0]        skid_out_data;
   logic               accept;
   logic               is_last;
   logic               last_fire;

   // Dropping run behaves exactly like reset: everything in flight is discarded.
   assign flush     = reset | ~run;
   assign dst_ready = skid_in_ready & (state_q == STREAM);
   assign accept    = dst_valid & dst_ready;
   assign is_last   = (beat_q == BEAT_LAST) && (batch_q == nbatch_q - BATCH_W'(1));
   assign last_fire = skid_out_valid & m_axis_tready & skid_out_data[DW];

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      batch_d   = batch_q;
      nbatch_d  = nbatch_q;
      started_d = started_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // started_q limits each run rising edge to a single start (or empty-run done)
            if (run && !started_q) begin
               started_d = 1'b1;
               if (nbatch != '0) begin
                  state_d  = STREAM;
                  nbatch_d = nbatch;
                  beat_d   = '0;
                  batch_d  = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         STREAM: begin
            if (accept) begin
               if (beat_q == BEAT_LAST) begin
                  beat_d = '0;
                  if (is_last) begin
                     state_d = DRAIN;
                  end else begin
                     batch_d = batch_q + BATCH_W'(1);
                  end
               end else begin
                  beat_d = beat_q + BCW'(1);
               end
            end
         end
         DRAIN: begin
            if (last_fire) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         state_q   <= IDLE;
         beat_q    <= '0;
         batch_q   <= '0;
         nbatch_q  <= '0;
         started_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         batch_q   <= batch_d;
         nbatch_q  <= nbatch_d;
         started_q <= started_d;
         done_q    <= done_d;
      end
   end

   axis_skid #(
      .W (DW + 1)
   ) u_skid (
      .clk       (clk),
      .rst       (flush),
      .in_valid  (accept),
      .in_ready  (skid_in_ready),
      .in_data   ({is_last, dst_data}),
      .out_valid (skid_out_valid),
      .out_ready (m_axis_tready),
      .out_data  (skid_out_data)
   );

   assign m_axis_tvalid = skid_out_valid;
   assign m_axis_tdata  = skid_out_data[DW-1:0];
   assign m_axis_tlast  = skid_out_valid & skid_out_data[DW];
   assign busy          = (state_q != IDLE);
   assign done          = done_q;

endmodule

// File: tb/tb_dst_axis_out.sv
// Scoreboard bench for dst_axis_out: the driver queues expected {last,data} per word,
// a negedge monitor pops and compares on every stream handshake.
module tb_dst_axis_out;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [15:0] nbatch;
   logic        dst_valid;
   logic [31:0] dst_data;
   logic        dst_ready;
   logic        m_axis_tvalid;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic        busy;
   logic        done;

   logic tog_mode   = 1'b0;
   logic tog        = 1'b0;
   logic tready_lvl = 1'b1;
   assign m_axis_tready = tog_mode ? tog : tready_lvl;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int hs_cnt = 0;
   int hs_tot = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int last_tag_cyc = -1;
   logic        prev_stall = 1'b0;
   logic [32:0] prev_word = '0;
   logic [32:0] mon_e;
   logic [32:0] exp_q[$];

   dst_axis_out #(
      .DW      (32),
      .BEATS   (16),
      .BATCH_W (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .nbatch        (nbatch),
      .dst_valid     (dst_valid),
      .dst_data      (dst_data),
      .dst_ready     (dst_ready),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial forever begin
      @(posedge clk);
      #1;
      tog = ~tog;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: scoreboard pop, hold stability, occupancy-based ready check, done counting.
   always @(negedge clk) begin
      if (reset || !run) begin
         exp_q.delete();
         acc_cnt    = 0;
         hs_cnt     = 0;
         prev_stall = 1'b0;
      end else begin
         if ((acc_cnt - hs_cnt) == 2) chk("skid_full_ready", dst_ready, 0);
         chk("tvalid_vs_occ", m_axis_tvalid, (acc_cnt != hs_cnt));
         if (prev_stall) begin
            chk("hold_valid", m_axis_tvalid, 1);
            chk("hold_word", {m_axis_tlast, m_axis_tdata}, prev_word);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            hs_cnt++;
            hs_tot++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got %0h want no beat", {m_axis_tlast, m_axis_tdata});
            end else begin
               mon_e = exp_q.pop_front();
               chk("beat", {m_axis_tlast, m_axis_tdata}, mon_e);
            end
            if (m_axis_tlast) last_tag_cyc = cyc;
         end
         if (dst_valid && dst_ready) acc_cnt++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_word  = {m_axis_tlast, m_axis_tdata};
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic send_word(input logic [31:0] d, input logic l);
      int n = 0;
      exp_q.push_back({l, d});
      dst_valid = 1'b1;
      dst_data  = d;
      @(negedge clk);
      while (!dst_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got no accept want accept of %0h", d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [15:0] n);
      nbatch = n;
      run    = 1'b1;
      @(posedge clk);
      #1;
      chk("busy_on_start", busy, 1);
   endtask

   task automatic stop_run();
      dst_valid = 1'b0;
      run       = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done want done pulse");
      end
      repeat (3) @(posedge clk);
      #1;
      chk("done_single", done_cnt - d0, 1);
      chk("queue_empty", exp_q.size(), 0);
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      int d0;
      int c0;
      int h0;
      reset     = 1'b1;
      run       = 1'b0;
      nbatch    = '0;
      dst_valid = 1'b0;
      dst_data  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_ready", dst_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // One batch at full rate
      d0 = done_cnt;
      start_run(16'd1);
      c0 = cyc;
      for (int i = 0; i < 16; i++) send_word(32'(i), (i == 15));
      dst_valid = 1'b0;
      wait_done(d0);
      chk("t1_last_cycle", last_tag_cyc, c0 + 16);
      chk("t1_done_cycle", done_cyc, c0 + 17);
      stop_run();

      // Three batches with tready toggling
      d0 = done_cnt;
      h0 = hs_tot;
      tog_mode = 1'b1;
      start_run(16'd3);
      for (int i = 0; i < 48; i++) send_word(32'(100 + i), (i == 47));
      dst_valid = 1'b0;
      wait_done(d0);
      tog_mode = 1'b0;
      chk("t2_beats", hs_tot - h0, 48);
      stop_run();

      // Long stall mid-batch
      d0 = done_cnt;
      tready_lvl = 1'b1;
      start_run(16'd1);
      for (int i = 0; i < 5; i++) send_word(32'(200 + i), 1'b0);
      tready_lvl = 1'b0;
      send_word(32'd205, 1'b0);
      dst_valid = 1'b1;
      dst_data  = 32'd206;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t3_ready_low", dst_ready, 0);
         chk("t3_valid", m_axis_tvalid, 1);
         chk("t3_data_held", m_axis_tdata, 204);
      end
      @(posedge clk);
      #1;
      tready_lvl = 1'b1;
      for (int i = 6; i < 16; i++) send_word(32'(200 + i), (i == 15));
      dst_valid = 1'b0;
      wait_done(d0);
      stop_run();

      // Extra word presented during DRAIN
      d0 = done_cnt;
      start_run(16'd1);
      for (int i = 0; i < 16; i++) send_word(32'(300 + i), (i == 15));
      dst_valid = 1'b1;
      dst_data  = 32'd999;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t4_ready_low", dst_ready, 0);
      end
      @(posedge clk);
      #1;
      dst_valid = 1'b0;
      wait_done(d0);
      stop_run();

      // run dropped at beat 7 with two words buffered, then a clean rerun
      start_run(16'd2);
      for (int i = 0; i < 6; i++) send_word(32'(400 + i), 1'b0);
      tready_lvl = 1'b0;
      send_word(32'd406, 1'b0);
      d0 = done_cnt;
      run       = 1'b0;
      dst_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_tvalid_flush", m_axis_tvalid, 0);
      chk("t5_busy_flush", busy, 0);
      chk("t5_ready_flush", dst_ready, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_no_done", done_cnt - d0, 0);
      tready_lvl = 1'b1;
      d0 = done_cnt;
      start_run(16'd1);
      for (int i = 0; i < 16; i++) send_word(32'(500 + i), (i == 15));
      dst_valid = 1'b0;
      wait_done(d0);
      stop_run();

      // Empty run: single done, no beats, never busy
      d0 = done_cnt;
      h0 = hs_tot;
      nbatch = 16'd0;
      run    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk("t6_busy", busy, 0);
         chk("t6_tvalid", m_axis_tvalid, 0);
      end
      chk("t6_done_once", done_cnt - d0, 1);
      chk("t6_no_beats", hs_tot - h0, 0);
      stop_run();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
